// File: rtl/axi_burst_master.sv
// axi_burst_master
// Issues one AXI4 INCR burst at a time, either a write or a read. A command
// (start address, beat count) is captured in IDLE. The block then drives the
// address channel. Write beats are passed from the wr_* stream to the W
// channel. Read beats are passed from the R channel to the rd_* stream.
// Completion is reported with a one-cycle done pulse and an error flag.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cmd_*               command handshake: write/read, byte address, len
//   wr_*                write-beat stream (data, strobes, valid/ready)
//   rd_*                read-beat stream (data, last, valid/ready)
//   done, done_err      completion pulse and its error flag
//   busy                high whenever the engine is not idle
//   m_axi_*             AXI4 master channels AW, W, B, AR, R
//
// Build option
//   AXI_BURST_MASTER_TIMEOUT_EN  adds a 16-bit watchdog. The watchdog aborts a
//                                transaction that makes no handshake progress.
module axi_burst_master #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 17,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  done_err,
    output logic                  busy,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int         SIZE_LOG2 = $clog2(STRB_WIDTH);
    localparam logic [2:0] AXSIZE    = 3'(SIZE_LOG2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    state_t                state_r;
    logic [ID_WIDTH-1:0]   id_r;
    logic [ID_WIDTH-1:0]   next_id_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [7:0]            len_r;
    logic [7:0]            cnt_r;
    logic                  cmd_ready_r;
    logic                  awvalid_r;
    logic                  arvalid_r;
    logic                  done_r;
    logic                  done_err_r;
    logic                  rerr_r;
    logic                  in_w_s;
    logic                  in_r_s;
    logic                  last_beat_s;
    logic                  w_hs_s;
    logic                  r_hs_s;
    logic                  r_beat_err_s;
    logic                  wd_expire_s;

    // Bursts start on a full-width beat boundary, so drop the sub-beat bits.
    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] mask;
        mask = {ADDR_WIDTH{1'b1}} << SIZE_LOG2;
        return a & mask;
    endfunction

    assign in_w_s      = (state_r == S_W);
    assign in_r_s      = (state_r == S_R);
    assign last_beat_s = (cnt_r == len_r);

    assign cmd_ready     = cmd_ready_r;
    assign busy          = (state_r != S_IDLE);
    assign done          = done_r;
    assign done_err      = done_err_r;

    assign m_axi_awid    = id_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awlen   = len_r;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_arid    = id_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_arlen   = len_r;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_r;

    // Beat channels are plain pass-throughs gated by the state, which keeps
    // the stream handshakes free of an extra pipeline stage.
    assign m_axi_wvalid  = in_w_s & wr_valid;
    assign wr_ready      = in_w_s & m_axi_wready;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = wr_strb;
    assign m_axi_wlast   = in_w_s & last_beat_s;
    assign m_axi_bready  = (state_r == S_B);
    assign rd_valid      = in_r_s & m_axi_rvalid;
    assign m_axi_rready  = in_r_s & rd_ready;
    assign rd_data       = m_axi_rdata;
    assign rd_last       = in_r_s & last_beat_s;

    assign w_hs_s = m_axi_wvalid & m_axi_wready;
    assign r_hs_s = m_axi_rvalid & m_axi_rready;

    // Per-beat read check: bad response, foreign ID or misplaced rlast.
    always_comb begin
        r_beat_err_s = 1'b0;
        if (r_hs_s) begin
            r_beat_err_s = (m_axi_rresp != 2'b00) || (m_axi_rid != id_r) ||
                           (m_axi_rlast != rd_last);
        end else begin
            r_beat_err_s = 1'b0;
        end
    end

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    logic [15:0] wd_r;
    logic        any_hs_s;

    assign any_hs_s = (cmd_valid & cmd_ready_r) | (awvalid_r & m_axi_awready) |
                      (arvalid_r & m_axi_arready) | w_hs_s | r_hs_s |
                      (m_axi_bvalid & m_axi_bready);
    assign wd_expire_s = (wd_r == 16'hFFFF);

    // Watchdog: counts stalled cycles of an active transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_r <= 16'd0;
        end else if (any_hs_s || (state_r == S_IDLE)) begin
            wd_r <= 16'd0;
        end else if (!wd_expire_s) begin
            wd_r <= wd_r + 16'd1;
        end
    end
`else
    assign wd_expire_s = 1'b0;
`endif

    // Transaction FSM with registered handshake and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            id_r        <= {ID_WIDTH{1'b0}};
            next_id_r   <= {ID_WIDTH{1'b0}};
            addr_r      <= {ADDR_WIDTH{1'b0}};
            len_r       <= 8'd0;
            cnt_r       <= 8'd0;
            cmd_ready_r <= 1'b0;
            awvalid_r   <= 1'b0;
            arvalid_r   <= 1'b0;
            done_r      <= 1'b0;
            done_err_r  <= 1'b0;
            rerr_r      <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            done_err_r <= 1'b0;
            if (wd_expire_s) begin
                state_r     <= S_IDLE;
                awvalid_r   <= 1'b0;
                arvalid_r   <= 1'b0;
                cmd_ready_r <= 1'b1;
                done_r      <= 1'b1;
                done_err_r  <= 1'b1;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        cmd_ready_r <= 1'b1;
                        if (cmd_valid && cmd_ready_r) begin
                            cmd_ready_r <= 1'b0;
                            addr_r      <= align_addr(cmd_addr);
                            len_r       <= cmd_len;
                            cnt_r       <= 8'd0;
                            rerr_r      <= 1'b0;
                            id_r        <= next_id_r;
                            next_id_r   <= next_id_r + {{(ID_WIDTH-1){1'b0}}, 1'b1};
                            if (cmd_write) begin
                                state_r   <= S_AW;
                                awvalid_r <= 1'b1;
                            end else begin
                                state_r   <= S_AR;
                                arvalid_r <= 1'b1;
                            end
                        end
                    end
                    S_AW: begin
                        if (m_axi_awready) begin
                            awvalid_r <= 1'b0;
                            state_r   <= S_W;
                        end
                    end
                    S_W: begin
                        if (w_hs_s) begin
                            if (last_beat_s) begin
                                state_r <= S_B;
                            end else begin
                                cnt_r <= cnt_r + 8'd1;
                            end
                        end
                    end
                    S_B: begin
                        if (m_axi_bvalid) begin
                            done_r      <= 1'b1;
                            done_err_r  <= (m_axi_bresp != 2'b00) || (m_axi_bid != id_r);
                            state_r     <= S_IDLE;
                            cmd_ready_r <= 1'b1;
                        end
                    end
                    S_AR: begin
                        if (m_axi_arready) begin
                            arvalid_r <= 1'b0;
                            state_r   <= S_R;
                        end
                    end
                    S_R: begin
                        if (r_hs_s) begin
                            if (last_beat_s) begin
                                done_r      <= 1'b1;
                                done_err_r  <= rerr_r | r_beat_err_s;
                                state_r     <= S_IDLE;
                                cmd_ready_r <= 1'b1;
                            end else begin
                                cnt_r  <= cnt_r + 8'd1;
                                rerr_r <= rerr_r | r_beat_err_s;
                            end
                        end
                    end
                    default: begin
                        state_r     <= S_IDLE;
                        awvalid_r   <= 1'b0;
                        arvalid_r   <= 1'b0;
                        cmd_ready_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 DATA_WIDTH, 64, AXI data width in bits; a power of two, at least 8.
REQ-002 ADDR_WIDTH, 17, AXI byte-address width.
REQ-003 STRB_WIDTH, DATA_WIDTH/8, width of wstrb and wr_strb.
REQ-004 ID_WIDTH, 8, AXI ID width.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; asynchronous assertion, active-low.
REQ-007 cmd_valid / cmd_ready  input / output  1 each  command handshake.
REQ-008 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  input  ADDR_WIDTH  start byte address.
REQ-010 cmd_len  input  8  beats minus 1, same meaning as AXI len.
REQ-011 wr_data / wr_strb  input  DATA_WIDTH / STRB_WIDTH  write beat data and byte enables.
REQ-012 wr_valid / wr_ready  input / output  1 each  write-beat handshake.
REQ-013 rd_data / rd_last  output  DATA_WIDTH / 1  read beat data; rd_last marks the final beat.
REQ-014 rd_valid / rd_ready  output / input  1 each  read-beat handshake.
REQ-015 done / done_err  output  1 each  one-cycle completion pulse and its error flag.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 m_axi_aw{id,addr,len,size,burst,valid} / m_axi_awready  output / input  AXI write-address channel.
REQ-018 m_axi_w{data,strb,last,valid} / m_axi_wready  output / input  AXI write-data channel.
REQ-019 m_axi_b{id,resp,valid} / m_axi_bready  input / output  AXI write-response channel.
REQ-020 m_axi_ar{id,addr,len,size,burst,valid} / m_axi_arready  output / input  AXI read-address channel.
REQ-021 m_axi_r{id,data,resp,last,valid} / m_axi_rready  input / output  AXI read-data channel.
REQ-022 m_axi_{aw,ar}lock = 0, m_axi_{aw,ar}cache = 4'b0011, m_axi_{aw,ar}prot = 3'b000, all constant outputs.

Function
REQ-023 The block SHALL have states IDLE, AW, W, B, AR, R, with at most one transaction outstanding.
REQ-024 cmd_ready SHALL be 1 only in IDLE; cmd_valid&&cmd_ready SHALL capture the command and move to AW (cmd_write=1) or AR (cmd_write=0) on the next cycle.
REQ-025 Address SHALL be cmd_addr with its low log2(STRB_WIDTH) bits zeroed; len = cmd_len; size = log2(STRB_WIDTH); burst = INCR (2'b01).
REQ-026 Transaction ID SHALL be an ID_WIDTH counter; it resets to 0, increments once per accepted command, and wraps.
REQ-027 A*valid SHALL be registered, rise on entry to AW/AR, and hold stable until the *ready handshake; the handshake moves AW->W and AR->R.
REQ-028 In W: m_axi_wvalid = wr_valid and wr_ready = m_axi_wready (combinational); wdata/wstrb pass through unchanged.
REQ-029 A beat counter SHALL count accepted beats; m_axi_wlast = (count == len); the last handshake moves W->B, so cmd_len=0 gives wlast on the first beat.
REQ-030 In B: m_axi_bready = 1. On bvalid, done pulses for 1 cycle, done_err = (bresp != 0) || (bid != issued ID), and the state returns to IDLE.
REQ-031 In R: rd_valid = m_axi_rvalid, m_axi_rready = rd_ready, rd_data = rdata, rd_last = (count == len).
REQ-032 In R: done_err SHALL be the sticky OR, over the burst, of rresp != 0, rid mismatch, and m_axi_rlast != rd_last. done pulses on the cycle after the final handshake, then the state returns to IDLE.
REQ-033 Outside W and R, wr_ready, rd_valid and m_axi_wvalid SHALL be 0.
REQ-034 4 KB crossings are the caller's responsibility; the block SHALL NOT split bursts.
REQ-035 Command-to-A*valid latency SHALL be 1 cycle; last-response-to-done latency SHALL be 1 cycle.

Reset
REQ-036 rst low SHALL asynchronously force IDLE, all valid/ready/done outputs to 0, and the ID and beat counters to 0, including in the middle of a burst.
REQ-037 The first cmd_ready=1 SHALL appear on the first clock edge after rst deasserts.

Configuration
REQ-038 With AXI_BURST_MASTER_TIMEOUT_EN defined, a 16-bit watchdog SHALL clear on any handshake and count in non-IDLE states; on reaching 0xFFFF it SHALL drop all valids, pulse done with done_err=1, and return to IDLE.
REQ-039 Without the macro, no watchdog logic SHALL exist and the block SHALL wait indefinitely.

Verification
REQ-040 Write cmd_addr=0x100, cmd_len=3, data 0x11..0x44, wstrb all-ones -> awaddr=0x100, awlen=3, awsize=3, wlast on beat 4 only, done=1, done_err=0.
REQ-041 Read the same address range -> rd_data 0x11..0x44, rd_last on beat 4, done_err=0.
REQ-042 cmd_len=0, cmd_addr=0x107 -> awaddr=0x100, a single beat with wlast=1.
REQ-043 bvalid held off 5 cycles, then bresp=2'b10 -> bready stays 1 throughout, done_err=1.
REQ-044 rst low during write beat 2 of 4 -> awvalid, wvalid and busy are 0 immediately; after release cmd_ready=1 and the next awid is 0.
REQ-045 rd_ready toggled every cycle, with rlast driven early on beat 2 of 4 -> data order preserved, done_err=1.
